feature_memory_responder: RTL and testbench

Responder end of the feature-map memory handshake driven by `memory_operation`. It accepts single-cycle read/write strobes with an address and returns registered read data with a valid pulse. It holds a small on-chip register-file buffer of `MEM_DEPTH` words. It sits between the layer address sequencer and the PE array data path, replacing the behavioural memory used in simulation.

---
 rtl/feature_memory_responder_if.sv | 32 +++
 rtl/feature_memory_responder.sv | 137 +++++++++++++
 tb/tb_feature_memory_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/feature_memory_responder_if.sv
// Request/response bundle between the layer address sequencer (master)
// and the feature-map memory responder (slave).
interface feature_memory_responder_if #(
    parameter int DATA_BIT_WIDTH         = 8,
    parameter int ADDRESS_BUS_BIT_WIDTH  = 32,
    parameter int MEMORY_STATE_BIT_WIDTH = 4
);
    // Handshake: a strobe (mem_rd_en_i / mem_wr_en_i) is a one-cycle request,
    // taken only on an edge where busy_o is low. Any strobe presented while
    // busy_o is high is dropped and latches overrun_o. A read answers with a
    // single read_valid_o pulse; read_data_o is valid while that pulse is high.
    logic                             mem_rd_en_i;
    logic                             mem_wr_en_i;
    logic [ADDRESS_BUS_BIT_WIDTH-1:0] address_i;
    logic [DATA_BIT_WIDTH-1:0]        write_data_i;
    logic [DATA_BIT_WIDTH-1:0]        read_data_o;
    logic                             read_valid_o;
    logic                             busy_o;
    logic                             overrun_o;
    logic                             access_error_o;
    logic [MEMORY_STATE_BIT_WIDTH-1:0] state_o;

    modport master (
        output mem_rd_en_i, mem_wr_en_i, address_i, write_data_i,
        input  read_data_o, read_valid_o, busy_o, overrun_o, access_error_o, state_o
    );

    modport slave (
        input  mem_rd_en_i, mem_wr_en_i, address_i, write_data_i,
        output read_data_o, read_valid_o, busy_o, overrun_o, access_error_o, state_o
    );
endinterface

// File: rtl/feature_memory_responder.sv
// Feature-map memory responder: strobe-driven register-file buffer with registered read data.
// Optional bounds checking on the full request address is enabled by FEATURE_MEM_BOUNDS_CHECK_EN.
module feature_memory_responder #(
    parameter int DATA_BIT_WIDTH        = 8,
    parameter int ADDRESS_BUS_BIT_WIDTH = 32,
    parameter int MEM_DEPTH             = 16,
    parameter int MEM_ADDR_BIT_WIDTH    = 4   // must equal log2(MEM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       layer_reset_n,
    feature_memory_responder_if.slave  mem_if
);

    localparam int MEMORY_STATE_BIT_WIDTH = 4;

    typedef enum logic [MEMORY_STATE_BIT_WIDTH-1:0] {
        IDLE         = 4'd0,
        WRITE_COMMIT = 4'd1,
        READ_FETCH   = 4'd2,
        READ_RESP    = 4'd3
    } mem_state_e;

    mem_state_e                    state_q;
    logic [MEM_ADDR_BIT_WIDTH-1:0] idx_q;
    logic [DATA_BIT_WIDTH-1:0]     wdata_q;
    logic                          oor_q;
    logic [DATA_BIT_WIDTH-1:0]     read_data_q;
    logic                          read_valid_q;
    logic                          busy_q;
    logic                          overrun_q;
    logic [DATA_BIT_WIDTH-1:0]     mem_q [MEM_DEPTH];

    logic                          any_strobe;
    logic                          addr_oor;

    assign any_strobe = mem_if.mem_rd_en_i | mem_if.mem_wr_en_i;

`ifdef FEATURE_MEM_BOUNDS_CHECK_EN
    logic access_error_q;

    // The full bus address is compared, so aliases above MEM_DEPTH are caught.
    assign addr_oor = (mem_if.address_i >= ADDRESS_BUS_BIT_WIDTH'(MEM_DEPTH));
    assign mem_if.access_error_o = access_error_q;
`else
    logic unused_addr_hi;

    assign addr_oor              = 1'b0;
    assign unused_addr_hi        = ^mem_if.address_i[ADDRESS_BUS_BIT_WIDTH-1:MEM_ADDR_BIT_WIDTH];
    assign mem_if.access_error_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge layer_reset_n) begin
        if (!layer_reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wdata_q      <= '0;
            oor_q        <= 1'b0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef FEATURE_MEM_BOUNDS_CHECK_EN
            access_error_q <= 1'b0;
`endif
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            read_valid_q <= 1'b0;
`ifdef FEATURE_MEM_BOUNDS_CHECK_EN
            access_error_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (mem_if.mem_wr_en_i) begin
                        idx_q   <= mem_if.address_i[MEM_ADDR_BIT_WIDTH-1:0];
                        wdata_q <= mem_if.write_data_i;
                        oor_q   <= addr_oor;
                        busy_q  <= 1'b1;
                        state_q <= WRITE_COMMIT;
`ifdef FEATURE_MEM_BOUNDS_CHECK_EN
                        access_error_q <= addr_oor;
`endif
                        // A read issued alongside the write is lost.
                        if (mem_if.mem_rd_en_i) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (mem_if.mem_rd_en_i) begin
                        idx_q   <= mem_if.address_i[MEM_ADDR_BIT_WIDTH-1:0];
                        oor_q   <= addr_oor;
                        busy_q  <= 1'b1;
                        state_q <= READ_FETCH;
                    end
                end
                WRITE_COMMIT: begin
                    if (any_strobe) begin
                        overrun_q <= 1'b1;
                    end
                    if (!oor_q) begin
                        mem_q[idx_q] <= wdata_q;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                READ_FETCH: begin
                    if (any_strobe) begin
                        overrun_q <= 1'b1;
                    end
                    read_data_q  <= oor_q ? '0 : mem_q[idx_q];
                    read_valid_q <= 1'b1;
`ifdef FEATURE_MEM_BOUNDS_CHECK_EN
                    access_error_q <= oor_q;
`endif
                    state_q <= READ_RESP;
                end
                READ_RESP: begin
                    if (any_strobe) begin
                        overrun_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_if.read_data_o  = read_data_q;
    assign mem_if.read_valid_o = read_valid_q;
    assign mem_if.busy_o       = busy_q;
    assign mem_if.overrun_o    = overrun_q;
    assign mem_if.state_o      = state_q;

endmodule

// File: tb/tb_feature_memory_responder.sv
// Directed bench for feature_memory_responder: per-cycle vector table plus hand-written
// sequences for overrun, simultaneous strobes and mid-operation reset.
module tb_feature_memory_responder;

    localparam int DW = 8;
    localparam int AW = 32;
`ifdef FEATURE_MEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic clk = 1'b0;
    logic layer_reset_n;

    feature_memory_responder_if #(.DATA_BIT_WIDTH(DW), .ADDRESS_BUS_BIT_WIDTH(AW)) mem_if ();

    feature_memory_responder #(
        .DATA_BIT_WIDTH(DW), .ADDRESS_BUS_BIT_WIDTH(AW), .MEM_DEPTH(16), .MEM_ADDR_BIT_WIDTH(4)
    ) dut (
        .clk(clk),
        .layer_reset_n(layer_reset_n),
        .mem_if(mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          v;
        logic [DW-1:0] d;
        logic          busy;
        logic          ovr;
        logic          err;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wd, input logic v, input logic [DW-1:0] d,
                                input logic busy, input logic ovr, input logic err);
        vec_t r;
        r.rd = rd; r.wr = wr; r.addr = addr; r.wd = wd;
        r.v = v; r.d = d; r.busy = busy; r.ovr = ovr; r.err = err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs from a negedge, return at the following negedge.
    task automatic cycle(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
        mem_if.mem_rd_en_i  = rd;
        mem_if.mem_wr_en_i  = wr;
        mem_if.address_i    = a;
        mem_if.write_data_i = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Idle for n cycles; every valid pulse must match the head of exp_q.
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            if (mem_if.read_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got valid=1 data=0x%0h expected no response",
                             mem_if.read_data_o);
                end else begin
                    check("read_data", 32'(mem_if.read_data_o), 32'(exp_q.pop_front()));
                end
            end
            cycle(1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic do_reset();
        layer_reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        layer_reset_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        d1 = BC ? 8'hFF : 8'h5A;
        d2 = BC ? 8'h00 : 8'h5A;

        mem_if.mem_rd_en_i  = 1'b0;
        mem_if.mem_wr_en_i  = 1'b0;
        mem_if.address_i    = '0;
        mem_if.write_data_i = '0;
        layer_reset_n       = 1'b0;
        #1;
        check("rst_state",   32'(mem_if.state_o),        32'd0);
        check("rst_data",    32'(mem_if.read_data_o),    32'd0);
        check("rst_valid",   32'(mem_if.read_valid_o),   32'd0);
        check("rst_busy",    32'(mem_if.busy_o),         32'd0);
        check("rst_overrun", 32'(mem_if.overrun_o),      32'd0);
        check("rst_error",   32'(mem_if.access_error_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        layer_reset_n = 1'b1;

        //           rd    wr    addr    wd     v     data   busy  ovr   err
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h3,  8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h4,  8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h4,  8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'hF,  8'h3C, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h0,  8'h81, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'hF,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,  8'h00, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0));
        // Address 0x14 aliases 0x4 unless bounds checking rejects it.
        vecs.push_back(mk(1'b0, 1'b1, 32'h14, 8'h5A, 1'b0, 8'h81, 1'b1, 1'b0, BC));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h4,  8'h00, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b1, d1,    1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b0, d1,    1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h14, 8'h00, 1'b0, d1,    1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b1, d2,    1'b1, 1'b0, BC));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  8'h00, 1'b0, d2,    1'b0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
            check($sformatf("v%0d_valid", i), 32'(mem_if.read_valid_o),   32'(vecs[i].v));
            check($sformatf("v%0d_data", i),  32'(mem_if.read_data_o),    32'(vecs[i].d));
            check($sformatf("v%0d_busy", i),  32'(mem_if.busy_o),         32'(vecs[i].busy));
            check($sformatf("v%0d_ovr", i),   32'(mem_if.overrun_o),      32'(vecs[i].ovr));
            check($sformatf("v%0d_err", i),   32'(mem_if.access_error_o), 32'(vecs[i].err));
        end

        // Read strobe held for two cycles: one response, sticky overrun.
        exp_q.push_back(8'h00);
        cycle(1'b1, 1'b0, 32'h1, 8'h00);
        check("held_ovr_first", 32'(mem_if.overrun_o), 32'd0);
        cycle(1'b1, 1'b0, 32'h1, 8'h00);
        check("held_ovr_set", 32'(mem_if.overrun_o), 32'd1);
        watch(5);
        check("held_ovr_sticky", 32'(mem_if.overrun_o), 32'd1);
        check("held_pending", 32'(exp_q.size()), 32'd0);

        // Simultaneous read+write: write wins, read is discarded.
        do_reset();
        check("sim_ovr_after_rst", 32'(mem_if.overrun_o), 32'd0);
        cycle(1'b1, 1'b1, 32'h2, 8'hA5);
        check("sim_busy", 32'(mem_if.busy_o), 32'd1);
        check("sim_ovr", 32'(mem_if.overrun_o), 32'd1);
        watch(4);
        exp_q.push_back(8'hA5);
        cycle(1'b1, 1'b0, 32'h2, 8'h00);
        watch(3);
        check("sim_pending", 32'(exp_q.size()), 32'd0);
        check("sim_ovr_sticky", 32'(mem_if.overrun_o), 32'd1);

        // Reset asserted during READ_FETCH aborts the read and clears the array.
        do_reset();
        cycle(1'b0, 1'b1, 32'h5, 8'h77);
        watch(1);
        exp_q.push_back(8'h77);
        cycle(1'b1, 1'b0, 32'h5, 8'h00);
        watch(3);
        cycle(1'b1, 1'b0, 32'h5, 8'h00);
        check("mid_state_fetch", 32'(mem_if.state_o), 32'd2);
        layer_reset_n = 1'b0;
        #1;
        check("mid_rst_data",  32'(mem_if.read_data_o),  32'd0);
        check("mid_rst_valid", 32'(mem_if.read_valid_o), 32'd0);
        check("mid_rst_busy",  32'(mem_if.busy_o),       32'd0);
        check("mid_rst_state", 32'(mem_if.state_o),      32'd0);
        @(negedge clk);
        layer_reset_n = 1'b1;
        watch(4);
        exp_q.push_back(8'h00);
        cycle(1'b1, 1'b0, 32'h5, 8'h00);
        watch(3);
        check("mid_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
